// File: rtl/sram_1rw_pipe_if.sv
// Request/response bundle for the pipelined 1RW SRAM.
// The master drives requests and rsp_ready. The slave (the SRAM) drives the
// request-ready, the response signals and init_done.
interface sram_1rw_pipe_if #(
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_WIDTH = 6,
  parameter int NUM_WMASKS = 2
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [NUM_WMASKS-1:0] req_wmask;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  init_done;

  modport master (
    output req_valid, req_we, req_addr, req_wmask, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, init_done
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wmask, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, init_done
  );
endinterface

// File: rtl/sram_1rw_pipe.sv
// Parametrised single-port SRAM with a valid/ready request port.
// Reads have a configurable latency and land in a small response buffer.
// A credit counter reserves buffer space for every read still in flight,
// so backpressure never drops data. An optional FSM zero-fills the array
// after reset.
module sram_1rw_pipe #(
  parameter int DATA_WIDTH   = 128,
  parameter int ADDR_WIDTH   = 6,
  parameter int WSIZE        = 64,
  parameter int READ_LATENCY = 1,
  parameter int INIT_ZERO    = 1
) (
  input logic            clk,
  input logic            rst_aN,
  sram_1rw_pipe_if.slave bus
);

  localparam int DEPTH      = 1 << ADDR_WIDTH;
  localparam int NUM_WMASKS = DATA_WIDTH / WSIZE;
  localparam int BUF_DEPTH  = READ_LATENCY + 1;
  localparam int CNT_W      = $clog2(BUF_DEPTH + 1);
  localparam int PTR_W      = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

  if ((DATA_WIDTH % WSIZE) != 0) begin : g_bad_wsize
    $error("sram_1rw_pipe: DATA_WIDTH (%0d) must be a multiple of WSIZE (%0d)",
           DATA_WIDTH, WSIZE);
  end
  if ((READ_LATENCY < 1) || (READ_LATENCY > 3)) begin : g_bad_latency
    $error("sram_1rw_pipe: READ_LATENCY (%0d) must be in 1..3", READ_LATENCY);
  end

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] init_cnt_q;
  logic                  ready_q;
  logic                  init_done_q;

  logic [CNT_W-1:0]      credits_q, credits_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] buf_q [BUF_DEPTH];

  logic                  accept, rd_acc, wr_acc, pop, init_last, rsp_valid;
  logic                  push_vld;
  logic [DATA_WIDTH-1:0] push_dat;

  assign accept    = bus.req_valid && ready_q;
  assign rd_acc    = accept && !bus.req_we;
  assign wr_acc    = accept && bus.req_we;
  assign rsp_valid = (count_q != '0);
  assign pop       = rsp_valid && bus.rsp_ready;
  assign init_last = (state_q == ST_INIT) && (init_cnt_q == ADDR_WIDTH'(DEPTH - 1));

  // Buffer wrap for a depth that need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Next credit and occupancy values; written as if-chains so an unknown
  // accept or pop leaves the counters unchanged instead of going X.
  always_comb begin
    // NOTE: each always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    credits_d = credits_q;
    count_d   = count_q;
    if (rd_acc && !pop)      credits_d = credits_q + 1'b1;
    else if (pop && !rd_acc) credits_d = credits_q - 1'b1;
    if (push_vld && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push_vld) count_d = count_q - 1'b1;
  end

  // Init/run FSM with registered req_ready and init_done.
  always_ff @(posedge clk or negedge rst_aN) begin
    if (!rst_aN) begin
      // NOTE: sequential state always uses non-blocking assignments so every
      // register samples the pre-edge values of the others.
      state_q     <= (INIT_ZERO != 0) ? ST_INIT : ST_RUN;
      init_cnt_q  <= '0;
      init_done_q <= (INIT_ZERO == 0);
      ready_q     <= 1'b0;
    end else begin
      if (state_q == ST_INIT) begin
        init_cnt_q <= init_cnt_q + 1'b1;
        if (init_last) begin
          state_q     <= ST_RUN;
          init_done_q <= 1'b1;
        end
      end
      ready_q <= ((state_q == ST_RUN) || init_last) &&
                 (credits_d < CNT_W'(BUF_DEPTH));
    end
  end

  // Storage array: zero-fill during INIT, masked writes during RUN.
  // NOTE: the array has no reset; clearing it is the INIT sweep's job, and
  // the rst_aN term keeps the sweep from rewriting word 0 while held in reset.
  always_ff @(posedge clk) begin
    if ((state_q == ST_INIT) && rst_aN) begin
      mem_q[init_cnt_q] <= '0;
    end else if (wr_acc) begin
      for (int i = 0; i < NUM_WMASKS; i++) begin
        if (bus.req_wmask[i]) begin
          mem_q[bus.req_addr][i*WSIZE +: WSIZE] <= bus.req_wdata[i*WSIZE +: WSIZE];
        end
      end
    end
  end

  // Read pipeline: the buffer write is the last stage, so READ_LATENCY-1
  // register stages sit between the array read and the buffer.
  if (READ_LATENCY == 1) begin : g_lat1
    assign push_vld = rd_acc;
    assign push_dat = mem_q[bus.req_addr];
  end else begin : g_pipe
    logic [READ_LATENCY-2:0] vld_q;
    logic [DATA_WIDTH-1:0]   dat_q [READ_LATENCY-1];

    // Stage valid bits; flushed by reset so in-flight reads vanish.
    always_ff @(posedge clk or negedge rst_aN) begin
      if (!rst_aN) begin
        vld_q <= '0;
      end else begin
        vld_q[0] <= rd_acc;
        for (int i = 1; i < READ_LATENCY - 1; i++) vld_q[i] <= vld_q[i-1];
      end
    end

    // Stage data, only loaded alongside a valid read.
    always_ff @(posedge clk) begin
      if (rd_acc) dat_q[0] <= mem_q[bus.req_addr];
      for (int i = 1; i < READ_LATENCY - 1; i++) begin
        if (vld_q[i-1]) dat_q[i] <= dat_q[i-1];
      end
    end

    assign push_vld = vld_q[READ_LATENCY-2];
    assign push_dat = dat_q[READ_LATENCY-2];
  end

  // Response buffer control and the credit counter.
  always_ff @(posedge clk or negedge rst_aN) begin
    if (!rst_aN) begin
      credits_q <= '0;
      count_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
    end else begin
      credits_q <= credits_d;
      count_q   <= count_d;
      if (push_vld) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)      rd_ptr_q <= ptr_inc(rd_ptr_q);
    end
  end

  // Response buffer storage; occupancy gates the output, so no reset needed.
  always_ff @(posedge clk) begin
    if (push_vld) buf_q[wr_ptr_q] <= push_dat;
  end

  assign bus.req_ready = ready_q;
  assign bus.init_done = init_done_q;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_rdata = rsp_valid ? buf_q[rd_ptr_q] : '0;

endmodule

// File: doc/sram_1rw_pipe.md
Name: sram_1rw_pipe

Overview:
Parametrised single-port (1RW) SRAM model. It is the next-generation replacement for the fixed-size icache/dcache data macros. It has a valid/ready request port and a configurable read latency. Read data is buffered so none is lost under backpressure, and an optional post-reset zero-fill FSM clears the array. It sits between the cache controllers and the storage array.

Parameters:
DATA_WIDTH, 128, word width in bits
ADDR_WIDTH, 6, address bits; DEPTH = 1 << ADDR_WIDTH
WSIZE, 64, write-mask granularity in bits; NUM_WMASKS = DATA_WIDTH / WSIZE
READ_LATENCY, 1, cycles from read acceptance to rsp_valid; legal range 1..3
INIT_ZERO, 1, 1 = zero-fill every word after reset; 0 = contents undefined, ready immediately

Ports:
clk  input  1  single clock; all state updates on posedge
rst_aN  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  block can accept a request this cycle
req_we  input  1  1 = write, 0 = read
req_addr  input  ADDR_WIDTH  word address
req_wmask  input  NUM_WMASKS  per-slice write enable; bit i covers bits [i*WSIZE +: WSIZE]
req_wdata  input  DATA_WIDTH  write data
rsp_valid  output  1  read data available
rsp_ready  input  1  consumer takes read data
rsp_rdata  output  DATA_WIDTH  read data
init_done  output  1  high once the FSM is in RUN

Behaviour:
- Elaboration: $error if DATA_WIDTH % WSIZE != 0 or READ_LATENCY is outside 1..3.
- Reset (rst_aN low, asynchronous):
  - Outputs: rsp_valid=0, rsp_rdata=0, req_ready=0.
  - State: read pipeline and response buffer flushed; credit counter=0.
  - FSM goes to INIT if INIT_ZERO=1, else RUN.
  - Memory contents are not touched by reset.
- FSM:
  - INIT: ADDR_WIDTH-bit counter from 0. Writes all-zero to mem[counter] each cycle. After DEPTH cycles (counter = DEPTH-1 written), moves to RUN.
  - RUN: normal operation.
  - init_done = (state == RUN).
- Accept = req_valid && req_ready. One request per cycle, reads and writes share the port.
- req_ready = (state == RUN) && (credits < READ_LATENCY+1). It depends only on registered state, never on req_we or rsp_ready.
- Write accept:
  - At that posedge, updates only the slices whose req_wmask bit is set; mask=0 is accepted as a no-op.
  - No response is generated and credits are unchanged.
- Read accept:
  - Samples mem[req_addr] at that edge into a READ_LATENCY-deep pipeline.
  - The result enters the response buffer (depth READ_LATENCY+1) and rsp_valid rises exactly READ_LATENCY cycles after acceptance when the buffer was empty.
- Credits:
  - +1 on read accept, -1 on response pop (rsp_valid && rsp_ready); both in the same cycle leave it unchanged.
  - Credits never exceed READ_LATENCY+1, so the buffer cannot overflow.
- Ordering: responses are returned strictly in acceptance order.
- Read-after-write: a read accepted in the cycle after a write to the same address returns the new data.
- Backpressure: while rsp_valid && !rsp_ready, rsp_rdata and rsp_valid hold stable. rsp_rdata=0 whenever the buffer is empty.
- Throughput: with rsp_ready held high, back-to-back reads sustain 1 per cycle indefinitely.
- Reset mid-operation: in-flight reads are discarded with no response. If INIT_ZERO=1, the FSM restarts INIT from address 0.
- Unknown inputs (X on req_valid in RUN) must not corrupt credits. The bench checks this with assertions.

Test Plan:
- INIT_ZERO=1, ADDR_WIDTH=6: release reset -> req_ready=0 for exactly 64 cycles, init_done rises on cycle 64; reads of addr 0, 37 and 63 return 0.
- Write addr 5 = 0xAAAA..._5555..., mask 2'b11; next cycle read addr 5 -> rsp_valid after READ_LATENCY cycles, rsp_rdata equals the written value.
- Write addr 9 full pattern P, then write addr 9 with Q and mask 2'b01 -> read returns {P[127:64], Q[63:0]}.
- READ_LATENCY=3, rsp_ready=1, 20 back-to-back reads of addresses 0..19 -> 20 responses in order on consecutive cycles, req_ready never drops.
- READ_LATENCY=2, rsp_ready=0, reads issued each cycle -> exactly 3 accepted, then req_ready=0 and rsp_rdata stable. Raise rsp_ready -> all 3 drain in order and req_ready returns the cycle after the first pop.
- Assert rst_aN low with 2 reads in flight -> rsp_valid=0 immediately and no stale response after release; INIT repeats for 64 cycles.
